ltc2308_sampler: RTL
====================

// Module: ltc2308_sampler
// PURPOSE
//  Front-end sequencer for the DE10-Nano LTC2308 8-ch 12-bit ADC. Drives ADC_CONVST/SCK/SDI, reads ADC_SDO.
//  Scans enabled channels round-robin; emits tagged samples on a valid/ready stream to the HPS bridge.
//  Instantiated in bss_hps top level, clocked from FPGA_CLK1_50.
// PARAMETERS
//  SCK_DIV       2   clk cycles per SCK half-period (50 MHz / 4 = 12.5 MHz SCK)
//  CONVST_CYCLES 2   CONVST high time in clk cycles
//  CONV_CYCLES   80  conversion wait after CONVST falls (1.6 us at 50 MHz)
//  AVG_LOG2      2   log2 samples averaged per emitted sample (ADC_SAMPLER_AVG_EN only)
// PORTS
//  clk          in   1   system clock, 50 MHz
//  reset_n      in   1   async active-low reset
//  enable       in   1   run scan; sampled at frame start
//  ch_mask      in   8   enabled channels; sampled at frame start
//  uni          in   1   1 = unipolar, 0 = bipolar; goes to the UNI bit of the config word
//  adc_convst   out  1   LTC2308 CONVST
//  adc_sck      out  1   LTC2308 SCK
//  adc_sdi      out  1   LTC2308 SDI, config word
//  adc_sdo      in   1   LTC2308 SDO
//  sample_valid out  1   sample available
//  sample_ready in   1   consumer accepts when valid && ready
//  sample_data  out  12  conversion result
//  sample_ch    out  3   channel the result belongs to
//  busy         out  1   FSM not in IDLE
//  overrun      out  1   sticky: unaccepted sample was overwritten
//  overrun_clr  in   1   clears overrun; a clear in the same cycle as a new overrun loses (overrun stays 1)
// BEHAVIOUR
//  Reset (async): all outputs 0, FSM=IDLE, primed=0, channel pointer=0.
//  FSM: IDLE -> CONVST (CONVST_CYCLES, convst=1) -> CONV_WAIT (CONV_CYCLES) -> SHIFT -> EMIT -> CONVST or IDLE.
//   IDLE exits when enable && ch_mask!=0. EMIT -> CONVST if that still holds, else -> IDLE and primed=0.
//  SHIFT: 12 SCK periods. Each period: SCK low SCK_DIV clks, then high SCK_DIV clks; SCK idles low.
//   SDI changes only while SCK low. Bits 0-5 carry config MSB first: {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=uni, SLP=0}.
//   Bits 6-11 drive SDI=0. SDO is sampled on the clk where SCK rises; MSB first.
//  Pipeline: frame N data belongs to the config sent in frame N-1. The first frame after IDLE has primed=0;
//   its data is discarded (no EMIT output) and it sets primed=1. sample_ch carries the previous frame's channel.
//  Channel select at frame start: next set bit of ch_mask above the previous channel, ascending; wraps 7->0.
//   A single set bit repeats that channel. ch_mask/enable changes never abort a frame in progress.
//  EMIT (1 clk): loads sample_data/sample_ch and sets sample_valid=1 in the next cycle.
//   If valid&&!ready at load time, the old sample is overwritten and overrun=1.
//   sample_valid clears on valid&&ready unless a load happens in the same cycle.
//  Frame length = CONVST_CYCLES + CONV_CYCLES + 24*SCK_DIV + 1 = 131 clk at defaults.
//  Reset asserted mid-frame: immediate return to reset values (CONVST/SCK/SDI low); next frame is a priming frame.
// CONFIGURATION
//  `ADC_SAMPLER_AVG_EN defined: each channel converts 2**AVG_LOG2 consecutive frames (config held).
//   A (12+AVG_LOG2)-bit accumulator sums them; one EMIT per group with sample_data = sum >> AVG_LOG2 (truncate).
//   The priming frame is not counted.
//  Undefined: one EMIT per frame; no accumulator is built and AVG_LOG2 is ignored.
// STRUCTURE
//  Package bss_adc_pkg: FSM state enum, config bit positions, ch-to-config function, LTC2308 timing defaults.
//  Sub-module ltc2308_shifter: SCK generator + 12-bit SDI/SDO shift registers.
//   Ports: start, cfg[5:0], done, data[11:0].
//  Parent holds FSM, channel pointer, averaging, output register.
// TESTING (bench uses an LTC2308 behavioural model returning programmable per-channel codes)
//  1 Reset: reset_n=0 mid-SHIFT -> convst=sck=sdi=0, sample_valid=0, busy=0 within the same cycle.
//  2 Config: uni=1, ch_mask=8'h05 -> SDI words 100010 (ch0), 100110 (ch2), then 100010 again.
//    First emitted sample is tagged ch0.
//  3 Data: model ch0=12'hA5C, ch2=12'h3F1, ready=1 -> stream (0,A5C),(2,3F1),(0,A5C).
//    Frames are 131 clk apart; no output from the priming frame.
//  4 Backpressure: ready=0 across two EMITs -> data holds the newest sample, overrun=1.
//    overrun_clr pulse -> overrun=0.
//  5 Stop: enable=0 during CONV_WAIT -> frame completes, one sample emitted, IDLE, busy=0.
//    Re-enable -> a priming frame is seen again.
//  6 AVG_EN, AVG_LOG2=2, ch_mask=8'h02, model returns 100,101,102,103 -> single sample ch1, data=101.

Source files
------------

// File: rtl/bss_adc_pkg.sv
// Shared definitions for the LTC2308 sampler: state encoding, config-word layout,
// timing defaults and channel helpers.
package bss_adc_pkg;

    localparam int LTC_SCK_DIV       = 2;
    localparam int LTC_CONVST_CYCLES = 2;
    localparam int LTC_CONV_CYCLES   = 80;
    localparam int LTC_AVG_LOG2      = 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CONVST    = 3'd1;
    localparam logic [2:0] ST_CONV_WAIT = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_EMIT      = 3'd4;

    // Bit positions inside the 6-bit word, bit 5 is shifted out first.
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    function automatic logic [5:0] ltc_cfg_word(input logic [2:0] ch, input logic uni);
        logic [5:0] w;
        w          = '0;
        w[CFG_SD]  = 1'b1;
        w[CFG_OS]  = ch[0];
        w[CFG_S1]  = ch[2];
        w[CFG_S0]  = ch[1];
        w[CFG_UNI] = uni;
        w[CFG_SLP] = 1'b0;
        return w;
    endfunction

    // First set bit of mask at or above 'from', ascending with wrap.
    function automatic logic [2:0] next_set_ch(input logic [7:0] mask, input logic [2:0] from);
        logic [2:0] idx;
        logic       found;
        next_set_ch = from;
        found       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = from + 3'(i);
            if (!found && mask[idx]) begin
                next_set_ch = idx;
                found       = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/ltc2308_shifter.sv
// SCK generator and 12-bit serial exchange with the LTC2308: config out on SDI,
// conversion result in on SDO, MSB first.
module ltc2308_shifter #(
    parameter int SCK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  cfg,
    input  logic        sdo,
    output logic        sck,
    output logic        sdi,
    output logic        done,
    output logic [11:0] data
);
    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    logic             active_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       bit_q;
    logic             sck_q;
    logic             sdi_q;
    logic [5:0]       cfg_q;
    logic [11:0]      data_q;
    logic             half_end;

    assign half_end = (div_q == DIV_W'(SCK_DIV - 1));
    assign done     = active_q && sck_q && half_end && (bit_q == 4'd11);
    assign sck      = sck_q;
    assign sdi      = sdi_q;
    assign data     = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            cfg_q    <= '0;
            data_q   <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            div_q    <= '0;
            bit_q    <= '0;
            sck_q    <= 1'b0;
            sdi_q    <= cfg[5];
            cfg_q    <= {cfg[4:0], 1'b0};
        end else if (active_q) begin
            if (!half_end) begin
                div_q <= div_q + 1'b1;
            end else begin
                div_q <= '0;
                // SDO is captured on the same clk edge that raises SCK.
                if (!sck_q) begin
                    sck_q  <= 1'b1;
                    data_q <= {data_q[10:0], sdo};
                end else if (bit_q == 4'd11) begin
                    active_q <= 1'b0;
                    sck_q    <= 1'b0;
                    sdi_q    <= 1'b0;
                end else begin
                    bit_q <= bit_q + 4'd1;
                    sck_q <= 1'b0;
                    sdi_q <= cfg_q[5];
                    cfg_q <= {cfg_q[4:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/ltc2308_sampler.sv
// Round-robin LTC2308 scan sequencer with a valid/ready sample stream.
// Define ADC_SAMPLER_AVG_EN to average 2**AVG_LOG2 conversions per emitted sample.
module ltc2308_sampler
    import bss_adc_pkg::*;
#(
    parameter int SCK_DIV       = LTC_SCK_DIV,
    parameter int CONVST_CYCLES = LTC_CONVST_CYCLES,
    parameter int CONV_CYCLES   = LTC_CONV_CYCLES,
    parameter int AVG_LOG2      = LTC_AVG_LOG2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    input  logic        uni,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [11:0] sample_data,
    output logic [2:0]  sample_ch,
    output logic        busy,
    output logic        overrun,
    input  logic        overrun_clr
);
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q;
    logic [2:0]  ptr_q, ch_q, prev_ch_q, sch_q;
    logic        primed_q, convst_q, valid_q, overrun_q;
    logic [5:0]  cfg_q;
    logic [11:0] data_q, sh_data, load_data;
    logic        go, frame_start, sh_start, sh_done, load, adv_ptr;
    logic [2:0]  sel_ch;

    assign go = enable && (ch_mask != 8'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (go) state_d = ST_CONVST;
            ST_CONVST:    if (cnt_q == 16'(CONVST_CYCLES - 1)) state_d = ST_CONV_WAIT;
            ST_CONV_WAIT: if (cnt_q == 16'(CONV_CYCLES - 1)) state_d = ST_SHIFT;
            ST_SHIFT:     if (sh_done) state_d = ST_EMIT;
            ST_EMIT:      state_d = go ? ST_CONVST : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    assign frame_start = (state_d == ST_CONVST) && (state_q != ST_CONVST);
    assign sh_start    = (state_q == ST_CONV_WAIT) && (state_d == ST_SHIFT);

`ifdef ADC_SAMPLER_AVG_EN
    localparam int ACC_W = 12 + AVG_LOG2;

    logic [AVG_LOG2-1:0] cfg_cnt_q, acc_cnt_q;
    logic [ACC_W-1:0]    acc_q, acc_sum;
    logic                emit_data;

    // The config is held for a whole group; a new channel is picked only when the group count wraps.
    assign adv_ptr   = (cfg_cnt_q == '0);
    assign sel_ch    = adv_ptr ? next_set_ch(ch_mask, ptr_q) : ch_q;
    assign emit_data = (state_q == ST_EMIT) && primed_q;
    assign acc_sum   = acc_q + ACC_W'(sh_data);
    assign load      = emit_data && (acc_cnt_q == '1);
    assign load_data = 12'(acc_sum >> AVG_LOG2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_cnt_q <= '0;
            acc_cnt_q <= '0;
            acc_q     <= '0;
        end else if ((state_q == ST_EMIT) && !go) begin
            cfg_cnt_q <= '0;
            acc_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            if (frame_start) cfg_cnt_q <= cfg_cnt_q + 1'b1;
            if (emit_data) begin
                acc_cnt_q <= acc_cnt_q + 1'b1;
                acc_q     <= load ? '0 : acc_sum;
            end
        end
    end
`else
    assign adv_ptr   = 1'b1;
    assign sel_ch    = next_set_ch(ch_mask, ptr_q);
    assign load      = (state_q == ST_EMIT) && primed_q;
    assign load_data = sh_data;
`endif

    ltc2308_shifter #(.SCK_DIV(SCK_DIV)) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (sh_start),
        .cfg     (cfg_q),
        .sdo     (adc_sdo),
        .sck     (adc_sck),
        .sdi     (adc_sdi),
        .done    (sh_done),
        .data    (sh_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            ch_q      <= '0;
            prev_ch_q <= '0;
            primed_q  <= 1'b0;
            convst_q  <= 1'b0;
            cfg_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            sch_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + 16'd1;

            // Results lag configs by one frame, so the outgoing channel tag is the previous config's.
            if (frame_start) begin
                convst_q  <= 1'b1;
                prev_ch_q <= ch_q;
                ch_q      <= sel_ch;
                cfg_q     <= ltc_cfg_word(sel_ch, uni);
                if (adv_ptr) ptr_q <= sel_ch + 3'd1;
            end else if ((state_q == ST_CONVST) && (state_d != ST_CONVST)) begin
                convst_q <= 1'b0;
            end

            if (state_q == ST_EMIT) primed_q <= go;

            if (load) begin
                valid_q <= 1'b1;
                data_q  <= load_data;
                sch_q   <= prev_ch_q;
            end else if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end

            if (load && valid_q && !sample_ready) overrun_q <= 1'b1;
            else if (overrun_clr)                 overrun_q <= 1'b0;
        end
    end

    assign adc_convst   = convst_q;
    assign busy         = (state_q != ST_IDLE);
    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign sample_ch    = sch_q;
    assign overrun      = overrun_q;

endmodule
